// File: rtl/red_pitaya_filter_config.sv
// Shadow/active configuration writer for the cascaded filter set_filter word.
// A commit moves the shadow to the active word in one edge and starts a settle timer.
module red_pitaya_filter_config #(
  parameter int STAGES     = 1,
  parameter int SHIFTBITS  = 4,
  parameter int SETTLEBITS = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [1:0]  cfg_stage_i,
  input  logic [7:0]  cfg_byte_i,
  input  logic        cfg_we_i,
  input  logic        cfg_commit_i,
  output logic [31:0] set_filter_o,
  output logic        busy_o,
  output logic        pending_o,
  output logic        cfg_err_o
);
  localparam int CW = (1 << SHIFTBITS) - 1 + SETTLEBITS;

  // keeps filter_on, highpass and the shift field; clears reserved bits above shift
  localparam logic [7:0] BYTE_MASK = 8'hC0 | ((8'(1) << SHIFTBITS) - 8'(1));

  logic [STAGES-1:0][7:0] r_shadow, r_active;
  logic [CW-1:0]          r_cnt;
  logic                   r_busy, r_pending, r_err;

  logic [STAGES-1:0][7:0] w_shadow_nxt;
  logic                   w_wr_ok, w_wr_bad, w_any_on;
  logic [SHIFTBITS-1:0]   w_maxsh;
  logic [CW:0]            w_pow, w_pm1;
  logic [CW-1:0]          w_load;

  assign w_wr_bad = cfg_we_i && (32'(cfg_stage_i) >= STAGES);
  assign w_wr_ok  = cfg_we_i && !w_wr_bad;

  // Merge a write into the shadow first so a same-cycle commit picks it up
  always_comb begin
    w_shadow_nxt = r_shadow;
    for (int j = 0; j < STAGES; j++)
      if (w_wr_ok && cfg_stage_i == 2'(j))
        w_shadow_nxt[j] = cfg_byte_i & BYTE_MASK;
  end

  always_comb begin
    w_any_on = 1'b0;
    w_maxsh  = '0;
    for (int j = 0; j < STAGES; j++)
      if (w_shadow_nxt[j][7]) begin
        w_any_on = 1'b1;
        if (w_shadow_nxt[j][SHIFTBITS-1:0] > w_maxsh)
          w_maxsh = w_shadow_nxt[j][SHIFTBITS-1:0];
      end
  end

  // busy covers the loaded value plus the cycle the counter spends at 0
  assign w_pow  = (CW+1)'(1) << (32'(w_maxsh) + SETTLEBITS);
  assign w_pm1  = w_pow - (CW+1)'(1);
  assign w_load = w_pm1[CW-1:0];

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_pending <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_shadow <= w_shadow_nxt;
      if (cfg_commit_i) begin
        r_active  <= w_shadow_nxt;
        r_pending <= 1'b0;
        r_err     <= 1'b0;
        r_busy    <= w_any_on;
        r_cnt     <= w_any_on ? w_load : '0;
      end else begin
        r_pending <= r_pending | w_wr_ok;
        r_err     <= r_err | w_wr_bad;
        if (r_busy) begin
          if (r_cnt == '0) r_busy <= 1'b0;
          else             r_cnt  <= r_cnt - CW'(1);
        end
      end
    end
  end

  assign set_filter_o = 32'(r_active);
  assign busy_o       = r_busy;
  assign pending_o    = r_pending;
  assign cfg_err_o    = r_err;
endmodule

// File: tb/tb_red_pitaya_filter_config.sv
// Directed bench for red_pitaya_filter_config with STAGES=2, SHIFTBITS=4, SETTLEBITS=2.
module tb_red_pitaya_filter_config;
  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  stage;
  logic [7:0]  byt;
  logic        we, commit;
  logic [31:0] set_filter;
  logic        busy, pending, err;
  int          n_cmp = 0;
  int          n_bad = 0;

  red_pitaya_filter_config #(.STAGES(2), .SHIFTBITS(4), .SETTLEBITS(2)) dut (
    .clk_i(clk), .rstn_i(rstn), .cfg_stage_i(stage), .cfg_byte_i(byt),
    .cfg_we_i(we), .cfg_commit_i(commit), .set_filter_o(set_filter),
    .busy_o(busy), .pending_o(pending), .cfg_err_o(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // one cycle of stimulus, inputs released afterwards
  task automatic drive(input logic w, input logic [1:0] s, input logic [7:0] b, input logic c);
    we = w; stage = s; byt = b; commit = c;
    tick();
    we = 1'b0; commit = 1'b0;
  endtask

  // counts sampled busy cycles, including the one already visible
  task automatic busy_len(input string tag, input int exp);
    int n = 0;
    while (busy && n < 2000) begin
      n++;
      tick();
    end
    chk(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    rstn = 1'b0; we = 1'b0; commit = 1'b0; stage = '0; byt = '0;
    tick(); tick();
    rstn = 1'b1;
    chk("rst_filter",  set_filter, 32'h0);
    chk("rst_busy",    32'(busy), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_err",     32'(err), 32'h0);

    drive(1'b1, 2'd0, 8'h83, 1'b0);
    drive(1'b1, 2'd1, 8'hC5, 1'b0);
    chk("wr_pending", 32'(pending), 32'h1);
    chk("wr_filter_held", set_filter, 32'h0);
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    chk("commit_filter",  set_filter, 32'h0000C583);
    chk("commit_pending", 32'(pending), 32'h0);
    chk("commit_busy",    32'(busy), 32'h1);
    busy_len("busy_len_128", 128);

    drive(1'b1, 2'd3, 8'h81, 1'b0);
    chk("oor_err",     32'(err), 32'h1);
    chk("oor_pending", 32'(pending), 32'h0);
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    chk("oor_commit_err",    32'(err), 32'h0);
    chk("oor_commit_filter", set_filter, 32'h0000C583);

    drive(1'b1, 2'd0, 8'hBF, 1'b0);
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    chk("mask_filter", set_filter, 32'h0000C58F);
    chk("long_busy",   32'(busy), 32'h1);
    for (int i = 0; i < 100; i++) tick();
    chk("long_busy_100", 32'(busy), 32'h1);
    drive(1'b1, 2'd0, 8'h82, 1'b0);
    drive(1'b1, 2'd1, 8'h00, 1'b0);
    chk("busy_wr_filter_held", set_filter, 32'h0000C58F);
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    chk("restart_filter", set_filter, 32'h00000082);
    busy_len("busy_len_16", 16);

    drive(1'b1, 2'd0, 8'h04, 1'b1);
    chk("wc_filter",  set_filter, 32'h00000004);
    chk("wc_busy",    32'(busy), 32'h0);
    chk("wc_pending", 32'(pending), 32'h0);

    drive(1'b1, 2'd2, 8'h81, 1'b1);
    chk("wc_oor_err",    32'(err), 32'h0);
    chk("wc_oor_filter", set_filter, 32'h00000004);

    drive(1'b1, 2'd1, 8'h83, 1'b1);
    chk("mid_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 5; i++) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("rst_mid_busy",   32'(busy), 32'h0);
    chk("rst_mid_filter", set_filter, 32'h0);
    tick();
    chk("rst_mid_busy_after", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
